// File: rtl/matrix_pkg.sv
// Shared types and defaults for the LED matrix scan engine: scan phase enum,
// default geometry/timing constants and a one-hot decode helper.
package matrix_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_e;

    localparam int DEF_ROWS         = 7;
    localparam int DEF_COLS         = 5;
    localparam int DEF_PWM_BITS     = 3;
    localparam int DEF_BLANK_CYCLES = 2;

    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/scan_sequencer.sv
// Column scan sequencer: BLANK/DRIVE phase FSM with column and dwell counters,
// plus a combinational strobe on the last DRIVE cycle of the last column.
module scan_sequencer
    import matrix_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int PWM_BITS     = DEF_PWM_BITS,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                clock_i,
    input  logic                reset_i,
    output phase_e              phase_o,
    output logic [CW-1:0]       col_o,
    output logic [PWM_BITS-1:0] dwell_o,
    output logic                frame_end_o
);

    localparam int DWELL   = 2 ** PWM_BITS;
    localparam int CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
    localparam int NW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [NW-1:0] BLANK_LAST = NW'(BLANK_CYCLES - 1);
    localparam logic [NW-1:0] DWELL_LAST = NW'(DWELL - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

    phase_e        phase_q, phase_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] col_q, col_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q <= BLANK;
            cnt_q   <= '0;
            col_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
        end
    end

    // One shared counter serves both phases; it restarts at each phase change.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        col_d   = col_q;
        case (phase_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    phase_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    phase_d = BLANK;
                    cnt_d   = '0;
                    col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                end
            end
            default: begin
                phase_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        phase_o     = phase_q;
        col_o       = col_q;
        dwell_o     = cnt_q[PWM_BITS-1:0];
        frame_end_o = (phase_q == DRIVE) && (cnt_q == DWELL_LAST) && (col_q == COL_LAST);
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// LED matrix scan engine: double-buffered frame store, frame-boundary swap,
// per-dwell PWM brightness and registered row/column drive.
module led_matrix_scanner
    import matrix_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int PWM_BITS     = DEF_PWM_BITS,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                wr_en_i,
    input  logic [CW-1:0]       wr_col_i,
    input  logic [ROWS-1:0]     wr_data_i,
    input  logic                swap_req_i,
    input  logic [PWM_BITS:0]   brightness_i,
    output logic [ROWS-1:0]     row_o,
    output logic [COLS-1:0]     col_sel_o,
    output logic                frame_start_o,
    output logic                swap_done_o
);

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    phase_e              phase;
    logic [CW-1:0]       col;
    logic [PWM_BITS-1:0] dwell;
    logic                frame_end;

    scan_sequencer #(
        .COLS         (COLS),
        .PWM_BITS     (PWM_BITS),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_seq (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .phase_o     (phase),
        .col_o       (col),
        .dwell_o     (dwell),
        .frame_end_o (frame_end)
    );

    logic [1:0][COLS-1:0][ROWS-1:0] buf_q;
    logic                           front_q, front_d;
    logic                           pend_q, pend_d;
    logic                           swap_hit;
    logic                           swap_hit_q;
    logic                           swap_done_q;
    logic [ROWS-1:0]                front_pat;
    logic [ROWS-1:0]                row_q, row_d;
    logic [COLS-1:0]                col_sel_q, col_sel_d;
    logic                           frame_start_q, frame_start_d;
    logic [31:0]                    col_oh;

    // A request seen in the boundary cycle itself is honoured immediately.
    assign swap_hit = frame_end && (pend_q || swap_req_i);

    always_comb begin
        pend_d  = pend_q;
        front_d = front_q;
        if (swap_req_i) pend_d = 1'b1;
        if (swap_hit) begin
            pend_d  = 1'b0;
            front_d = ~front_q;
        end
    end

    // Writes target whichever buffer is back this cycle, so a boundary-cycle
    // write lands in the buffer about to become front.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            buf_q <= '0;
        end else if (wr_en_i && (wr_col_i <= COL_LAST)) begin
            buf_q[~front_q][wr_col_i] <= wr_data_i;
        end
    end

    assign front_pat = buf_q[front_q][col];

    always_comb begin
        row_d         = '0;
        col_sel_d     = '0;
        frame_start_d = 1'b0;
        col_oh        = onehot(32'(col));
        if (phase == DRIVE) begin
            col_sel_d     = col_oh[COLS-1:0];
            frame_start_d = (dwell == '0) && (col == '0);
            if ({1'b0, dwell} < brightness_i) row_d = front_pat;
        end
    end

    // swap_done is delayed one extra stage so it lines up with the registered
    // output timeline rather than the sequencer state.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            front_q       <= 1'b0;
            pend_q        <= 1'b0;
            swap_hit_q    <= 1'b0;
            swap_done_q   <= 1'b0;
            row_q         <= '0;
            col_sel_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            front_q       <= front_d;
            pend_q        <= pend_d;
            swap_hit_q    <= swap_hit;
            swap_done_q   <= swap_hit_q;
            row_q         <= row_d;
            col_sel_q     <= col_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_o         = row_q;
    assign col_sel_o     = col_sel_q;
    assign frame_start_o = frame_start_q;
    assign swap_done_o   = swap_done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: per-frame expected scan streams are
// queued from the intended image and compared cycle by cycle.
module tb_led_matrix_scanner;

    localparam int ROWS         = 7;
    localparam int COLS         = 5;
    localparam int PWM_BITS     = 3;
    localparam int BLANK_CYCLES = 2;
    localparam int DWELL        = 2 ** PWM_BITS;
    localparam int FRAME        = COLS * (BLANK_CYCLES + DWELL);
    localparam int CW           = $clog2(COLS);

    typedef logic [ROWS-1:0] pat_t [COLS];

    logic                clock;
    logic                reset;
    logic                wr_en;
    logic [CW-1:0]       wr_col;
    logic [ROWS-1:0]     wr_data;
    logic                swap_req;
    logic [PWM_BITS:0]   brightness;
    logic [ROWS-1:0]     row;
    logic [COLS-1:0]     col_sel;
    logic                frame_start;
    logic                swap_done;

    int n_vec    = 0;
    int n_err    = 0;
    int sd_count = 0;

    led_matrix_scanner #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .PWM_BITS     (PWM_BITS),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .wr_en_i       (wr_en),
        .wr_col_i      (wr_col),
        .wr_data_i     (wr_data),
        .swap_req_i    (swap_req),
        .brightness_i  (brightness),
        .row_o         (row),
        .col_sel_o     (col_sel),
        .frame_start_o (frame_start),
        .swap_done_o   (swap_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the scan invariants there.
    task automatic tick();
        @(negedge clock);
        if (swap_done) sd_count++;
        check("onehot0", 32'($onehot0(col_sel)), 32'd1);
        if (col_sel == '0) check("dark_row", 32'(row), 32'd0);
    endtask

    task automatic wait_fs(output int n);
        bit found = 1'b0;
        n = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            tick();
            n++;
            if (frame_start) found = 1'b1;
        end
        check("fs_wait", 32'(found), 32'd1);
    endtask

    task automatic wait_sd();
        bit found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            tick();
            if (swap_done) found = 1'b1;
        end
        check("sd_wait", 32'(found), 32'd1);
    endtask

    task automatic release_and_check();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= BLANK_CYCLES + 1; i++) begin
            @(posedge clock);
            #1;
            if (i <= BLANK_CYCLES) begin
                check("pre_fs_colsel", 32'(col_sel), 32'd0);
            end else begin
                check("fs_colsel", 32'(col_sel), 32'd1);
                check("fs_pulse", 32'(frame_start), 32'd1);
            end
        end
        @(negedge clock);
    endtask

    // Called in the frame_start cycle; compares one whole frame.
    task automatic frame_check(input string tag, input pat_t pats, input int bright);
        logic [COLS+ROWS-1:0] q[$];
        logic [COLS+ROWS-1:0] e;
        for (int c = 0; c < COLS; c++) begin
            for (int d = 0; d < DWELL; d++)
                q.push_back({COLS'(1 << c), (d < bright) ? pats[c] : ROWS'(0)});
            for (int b = 0; b < BLANK_CYCLES; b++)
                q.push_back('0);
        end
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) tick();
            e = q.pop_front();
            check(tag, 32'({col_sel, row}), 32'(e));
        end
    endtask

    task automatic write_img(input pat_t pats);
        for (int c = 0; c < COLS; c++) begin
            wr_en   = 1'b1;
            wr_col  = CW'(c);
            wr_data = pats[c];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    initial begin
        pat_t img_a = '{7'h7F, 7'h41, 7'h41, 7'h41, 7'h7F};
        pat_t img_b = '{7'h55, 7'h2A, 7'h55, 7'h2A, 7'h55};
        pat_t img_z = '{default: '0};
        int   n;
        int   sd0;

        reset      = 1'b0;
        wr_en      = 1'b0;
        wr_col     = '0;
        wr_data    = '0;
        swap_req   = 1'b0;
        brightness = 4'd8;
        #2 reset = 1'b1;
        repeat (3) tick();
        check("rst_row", 32'(row), 32'd0);
        check("rst_colsel", 32'(col_sel), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_sd", 32'(swap_done), 32'd0);

        release_and_check();
        frame_check("boot_blank", img_z, 8);

        write_img(img_a);
        pulse_swap();
        wait_sd();
        wait_fs(n);
        check("sd_to_fs", 32'(n), 32'(BLANK_CYCLES));
        frame_check("img_a_full", img_a, 8);

        brightness = 4'd3;
        wait_fs(n);
        frame_check("img_a_b3", img_a, 3);
        brightness = 4'd0;
        wait_fs(n);
        frame_check("img_a_b0", img_a, 0);
        brightness = 4'd15;
        wait_fs(n);
        frame_check("img_a_b15", img_a, 15);
        brightness = 4'd8;

        write_img(img_b);
        sd0 = sd_count;
        repeat (3) begin
            wait_fs(n);
            frame_check("no_swap", img_a, 8);
        end
        check("no_swap_sd", 32'(sd_count), 32'(sd0));

        wait_fs(n);
        sd0 = sd_count;
        pulse_swap();
        repeat (5) tick();
        pulse_swap();
        repeat (5) tick();
        pulse_swap();
        wait_sd();
        wait_fs(n);
        frame_check("img_b", img_b, 8);
        wait_fs(n);
        frame_check("img_b_hold", img_b, 8);
        check("triple_req_sd", 32'(sd_count - sd0), 32'd1);

        wr_en   = 1'b1;
        wr_col  = CW'(5);
        wr_data = 7'h7F;
        tick();
        wr_en = 1'b0;
        pulse_swap();
        wait_sd();
        wait_fs(n);
        frame_check("oob_write", img_a, 8);

        wait_fs(n);
        repeat (3) tick();
        check("pre_rst_colsel", 32'(col_sel), 32'd1);
        check("pre_rst_row", 32'(row), 32'h7F);
        reset = 1'b1;
        #1;
        check("async_rst_row", 32'(row), 32'd0);
        check("async_rst_colsel", 32'(col_sel), 32'd0);
        check("async_rst_sd", 32'(swap_done), 32'd0);
        repeat (2) tick();
        release_and_check();
        frame_check("post_rst_blank", img_z, 8);
        pulse_swap();
        wait_sd();
        wait_fs(n);
        frame_check("post_rst_swap_blank", img_z, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
